sort_scheduler: RTL and testbench
=================================

SORT_SCHEDULER -- requirements
Module: sort_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 4: entries per lane queue, power of two.
- TIMER_W, 32: width of the timestamp counter.
- DELAY_1, 262500000: cycles from IR edge to lane-1 (red) fire.
- DELAY_2, 500000000: cycles from IR edge to lane-2 (green) fire.
- LATE_MAX, 12500000: cycles past due before an entry is dropped.
- ACK_TO, 8: cycles to wait for servo busy after a fire.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  system clock (125 MHz).
- rst_n  in  1  asynchronous active-low reset.
- obj_valid  in  1  one-cycle pulse: object passed IR gate.
- obj_color  in  2  color ID sampled with obj_valid (0 none, 1 red, 2 green, 3 blue).
- servo_busy  in  2  bit i-1 high while servo i is not idle.
- fire  out  2  bit i-1 is a one-cycle activate pulse to servo i.
- pending  out  2*clog2(DEPTH+1)  occupancy of lane 1 (low field) and lane 2 (high field).
- overflow  out  2  sticky per-lane bit: push was lost.
- miss_cnt  out  16  lane-1 count [7:0], lane-2 count [15:8]; each saturates at 255.
- clr_flags  in  1  one-cycle pulse: clears overflow and miss_cnt.

Function
REQ-003 Free-running TIMER_W-bit counter now shall increment every cycle and wrap modulo 2^TIMER_W.
REQ-004 obj_valid with color 1 shall push due=now+DELAY_1 (mod 2^TIMER_W) into lane 1; color 2 into lane 2 with DELAY_2; colors 0 and 3 are ignored.
REQ-005 Due test shall be wrap-safe: head is due when (now-due) mod 2^TIMER_W, read as signed, is >= 0; DELAY_x + LATE_MAX < 2^(TIMER_W-1) is a required legal-parameter condition.
REQ-006 Each lane shall be an independent in-order FIFO; lane 1 never blocks lane 2, and the reverse also holds.
REQ-007 Lane FSM states: IDLE (empty), ARMED (head not due), READY (head due, waiting on servo), FIRE, WAIT_ACK.
REQ-008 Transitions:
- IDLE->ARMED on non-empty.
- ARMED->READY when head is due.
- READY->FIRE when servo_busy is low.
- FIRE asserts fire for exactly one cycle, pops the head, then goes to WAIT_ACK.
- WAIT_ACK->IDLE/ARMED when servo_busy is seen high, or after ACK_TO cycles.
REQ-009 In READY, if now-due > LATE_MAX, the head shall be popped without firing and that lane's miss_cnt incremented (saturating).
REQ-010 Push to a full lane with no pop in the same cycle shall be discarded and set overflow for that lane.
REQ-011 Push and pop on a full lane in the same cycle shall both succeed; occupancy stays DEPTH.
REQ-012 Push into an empty lane shall be visible in pending the next cycle; the earliest fire is 2 cycles after due.
REQ-013 clr_flags coincident with a new overflow or miss event: the new event wins.
REQ-014 fire bits shall never be asserted on two consecutive cycles for the same lane.

Reset
REQ-015 rst_n low shall asynchronously clear the following: now, both FIFOs (pointers, occupancy), both FSMs to IDLE, fire=0, overflow=0, miss_cnt=0.
REQ-016 Entries in flight at reset shall be discarded; no fire shall occur until new pushes.

Structure
REQ-017 The package sort_pkg shall hold the following:
- color ID constants COLOR_NONE/RED/GREEN/BLUE.
- the lane-state enumeration.
- the default DELAY and LATE_MAX values.
REQ-018 The sub-module sort_lane shall hold one FIFO plus its FSM and miss counter. It is instantiated twice, once with DELAY_1 and once with DELAY_2.

Verification (DELAY_1=100, DELAY_2=200, DEPTH=4, LATE_MAX=50, ACK_TO=8)
REQ-019 Basic red: red at t=10 with servo idle -> fire[0] pulses exactly at t=112; no fire[1].
REQ-020 Lane independence: green at t=0, then red at t=20 -> fire[0] at t=122 and fire[1] at t=202.
REQ-021 Overflow: 5 reds in 5 consecutive cycles -> overflow[0]=1; exactly 4 fire[0] pulses, one per head cycle.
REQ-022 Late drop: red at t=0 with servo_busy[0] held high until t=200 -> no fire; miss_cnt[7:0]=1 at t=153.
REQ-023 Wrap: now preloaded to 2^32-50, then a red -> fire 102 cycles later despite counter wrap.
REQ-024 Reset mid-flight: 3 reds queued, rst_n pulsed low at t=50 -> pending=0 and no fire thereafter.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and types for the two-lane color-sort servo scheduler.
package sort_pkg;

    localparam logic [1:0] COLOR_NONE  = 2'd0;
    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    typedef enum logic [2:0] {
        LANE_IDLE,
        LANE_ARMED,
        LANE_READY,
        LANE_FIRE,
        LANE_WAIT_ACK
    } lane_state_t;

    localparam int unsigned DEFAULT_DELAY_1  = 262_500_000;
    localparam int unsigned DEFAULT_DELAY_2  = 500_000_000;
    localparam int unsigned DEFAULT_LATE_MAX = 12_500_000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sort_lane.sv
// One sort lane: in-order FIFO of due timestamps, the servo-handshake FSM,
// a sticky overflow flag and a saturating miss counter.
module sort_lane
    import sort_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TIMER_W  = 32,
    parameter int unsigned DELAY    = DEFAULT_DELAY_1,
    parameter int unsigned LATE_MAX = DEFAULT_LATE_MAX,
    parameter int unsigned ACK_TO   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [TIMER_W-1:0]           now,
    input  logic                         push,
    input  logic                         servo_busy,
    input  logic                         clr_flags,
    output logic                         fire,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [7:0]                   miss_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ACK_W = $clog2(ACK_TO + 1);

    logic [TIMER_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    lane_state_t        state_q, state_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic               fire_q, fire_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         miss_q, miss_d;

    logic [TIMER_W-1:0] head_age;
    logic               empty, full, head_due, head_late;
    logic               pop, push_ok, miss_evt;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_age  = now - mem_q[rd_ptr_q];
    // Age read as signed keeps the due test correct across counter wrap.
    assign head_due  = ~head_age[TIMER_W-1];
    assign head_late = head_due && (head_age > TIMER_W'(LATE_MAX));
    assign push_ok   = push && (!full || pop);

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        pop       = 1'b0;
        miss_evt  = 1'b0;
        case (state_q)
            LANE_IDLE: begin
                if (!empty) state_d = LANE_ARMED;
            end
            LANE_ARMED: begin
                if (head_due) state_d = LANE_READY;
            end
            LANE_READY: begin
                if (head_late) begin
                    pop      = 1'b1;
                    miss_evt = 1'b1;
                    state_d  = (count_q > CNT_W'(1)) ? LANE_ARMED : LANE_IDLE;
                end else if (!servo_busy) begin
                    state_d = LANE_FIRE;
                end
            end
            LANE_FIRE: begin
                pop       = 1'b1;
                ack_cnt_d = '0;
                state_d   = LANE_WAIT_ACK;
            end
            LANE_WAIT_ACK: begin
                if (servo_busy || ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
                    state_d = empty ? LANE_IDLE : LANE_ARMED;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            default: state_d = LANE_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        fire_d = (state_d == LANE_FIRE);
        // A new event in the same cycle as a clear survives the clear.
        overflow_d = overflow_q;
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end
        miss_d = clr_flags ? 8'd0 : miss_q;
        if (miss_evt) miss_d = sat_inc8(miss_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= LANE_IDLE;
            ack_cnt_q  <= '0;
            fire_q     <= 1'b0;
            overflow_q <= 1'b0;
            miss_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            fire_q     <= fire_d;
            overflow_q <= overflow_d;
            miss_q     <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= now + TIMER_W'(DELAY);
    end

    assign fire     = fire_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign miss_cnt = miss_q;

endmodule

// File: rtl/sort_scheduler.sv
// Two-lane servo scheduler: timestamps red/green objects at the IR gate and
// fires each lane's servo once its delay has elapsed.
module sort_scheduler
    import sort_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        TIMER_W  = 32,
    parameter int unsigned        DELAY_1  = DEFAULT_DELAY_1,
    parameter int unsigned        DELAY_2  = DEFAULT_DELAY_2,
    parameter int unsigned        LATE_MAX = DEFAULT_LATE_MAX,
    parameter int unsigned        ACK_TO   = 8,
    parameter logic [TIMER_W-1:0] NOW_INIT = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           obj_valid,
    input  logic [1:0]                     obj_color,
    input  logic [1:0]                     servo_busy,
    output logic [1:0]                     fire,
    output logic [2*$clog2(DEPTH+1)-1:0]   pending,
    output logic [1:0]                     overflow,
    output logic [15:0]                    miss_cnt,
    input  logic                           clr_flags
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TIMER_W-1:0] now_q, now_d;

    assign now_d = now_q + TIMER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q <= NOW_INIT;
        end else begin
            now_q <= now_d;
        end
    end

    // Lane index 0 serves red with DELAY_1, lane index 1 serves green with DELAY_2.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int unsigned LANE_DELAY = (gi == 0) ? DELAY_1 : DELAY_2;
        localparam logic [1:0]  LANE_COLOR = (gi == 0) ? COLOR_RED : COLOR_GREEN;

        sort_lane #(
            .DEPTH    (DEPTH),
            .TIMER_W  (TIMER_W),
            .DELAY    (LANE_DELAY),
            .LATE_MAX (LATE_MAX),
            .ACK_TO   (ACK_TO)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .now        (now_q),
            .push       (obj_valid && (obj_color == LANE_COLOR)),
            .servo_busy (servo_busy[gi]),
            .clr_flags  (clr_flags),
            .fire       (fire[gi]),
            .count      (pending[gi*CNT_W +: CNT_W]),
            .overflow   (overflow[gi]),
            .miss_cnt   (miss_cnt[gi*8 +: 8])
        );
    end

endmodule

// File: tb/tb_sort_scheduler.sv
// Bench for sort_scheduler: directed single-object table, hand-written corner
// sequences, then randomized traffic against a queue-based timing model.
module tb_sort_scheduler;
    import sort_pkg::*;

    localparam int DEPTH = 4;
    localparam int D1    = 100;
    localparam int D2    = 200;
    localparam int LATE  = 50;
    localparam int ACKT  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        obj_valid = 1'b0;
    logic [1:0]  obj_color = 2'd0;
    logic [1:0]  servo_busy = 2'd0;
    logic        clr_flags = 1'b0;
    logic [1:0]  fire, fire_w, overflow, overflow_w;
    logic [5:0]  pending, pending_w;
    logic [15:0] miss_cnt, miss_cnt_w;

    int checks = 0;
    int errors = 0;
    int cyc;
    int f0_log[$], f1_log[$], w0_log[$], w1_log[$];
    logic [1:0] prev_fire = 2'b00, prev_fire_w = 2'b00;

    typedef struct {
        int         t_push;
        logic [1:0] color;
        int         exp0;
        int         exp1;
    } vec_t;
    vec_t vecs[6];

    int         mq[2][$];
    int         head_fire[2];
    int         last_fire[2];
    logic [1:0] m_ovf, exp_fire;
    logic [5:0] exp_pend;

    sort_scheduler #(
        .DEPTH(DEPTH), .TIMER_W(32), .DELAY_1(D1), .DELAY_2(D2),
        .LATE_MAX(LATE), .ACK_TO(ACKT), .NOW_INIT(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .obj_valid(obj_valid), .obj_color(obj_color),
        .servo_busy(servo_busy), .fire(fire), .pending(pending),
        .overflow(overflow), .miss_cnt(miss_cnt), .clr_flags(clr_flags)
    );

    // Same design with the timestamp counter starting 50 cycles before wrap.
    sort_scheduler #(
        .DEPTH(DEPTH), .TIMER_W(32), .DELAY_1(D1), .DELAY_2(D2),
        .LATE_MAX(LATE), .ACK_TO(ACKT), .NOW_INIT(32'hFFFF_FFCE)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .obj_valid(obj_valid), .obj_color(obj_color),
        .servo_busy(servo_busy), .fire(fire_w), .pending(pending_w),
        .overflow(overflow_w), .miss_cnt(miss_cnt_w), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < 2; l++) begin
                if (fire[l]) begin
                    checks++;
                    if (prev_fire[l]) begin
                        errors++;
                        $display("FAIL back_to_back lane%0d cycle=%0d actual=1 required=0", l + 1, cyc);
                    end
                end
                if (fire_w[l]) begin
                    checks++;
                    if (prev_fire_w[l]) begin
                        errors++;
                        $display("FAIL back_to_back_wrap lane%0d cycle=%0d actual=1 required=0", l + 1, cyc);
                    end
                end
            end
            if (fire[0])   f0_log.push_back(cyc);
            if (fire[1])   f1_log.push_back(cyc);
            if (fire_w[0]) w0_log.push_back(cyc);
            if (fire_w[1]) w1_log.push_back(cyc);
            prev_fire   = fire;
            prev_fire_w = fire_w;
        end else begin
            prev_fire   = 2'b00;
            prev_fire_w = 2'b00;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_fire(input string name, input int q[$], input int exp);
        chk({name, "_count"}, q.size(), (exp < 0) ? 0 : 1);
        if (exp >= 0 && q.size() > 0) chk({name, "_time"}, q[0], exp);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_obj(input logic [1:0] c);
        obj_valid = 1'b1;
        obj_color = c;
        @(posedge clk);
        #1;
        obj_valid = 1'b0;
        obj_color = 2'd0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        obj_valid  = 1'b0;
        obj_color  = 2'd0;
        servo_busy = 2'b00;
        clr_flags  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        f0_log.delete();
        f1_log.delete();
        w0_log.delete();
        w1_log.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{t_push: 10, color: COLOR_RED,   exp0: 112, exp1: -1};
        vecs[1] = '{t_push: 0,  color: COLOR_GREEN, exp0: -1,  exp1: 202};
        vecs[2] = '{t_push: 5,  color: COLOR_BLUE,  exp0: -1,  exp1: -1};
        vecs[3] = '{t_push: 7,  color: COLOR_NONE,  exp0: -1,  exp1: -1};
        vecs[4] = '{t_push: 37, color: COLOR_RED,   exp0: 139, exp1: -1};
        vecs[5] = '{t_push: 40, color: COLOR_GREEN, exp0: -1,  exp1: 242};

        do_reset();
        chk("reset_fire", fire, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_miss", miss_cnt, 0);

        // Single objects: fire time per lane, and wrap-preloaded copy must agree.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            goto(vecs[i].t_push);
            push_obj(vecs[i].color);
            chk("vec_pending", pending,
                (vecs[i].color == COLOR_RED) ? 1 : (vecs[i].color == COLOR_GREEN) ? 8 : 0);
            goto(300);
            chk_fire("vec_fire0", f0_log, vecs[i].exp0);
            chk_fire("vec_fire1", f1_log, vecs[i].exp1);
            chk_fire("wrap_fire0", w0_log, vecs[i].exp0);
            chk_fire("wrap_fire1", w1_log, vecs[i].exp1);
        end

        // Lane independence.
        do_reset();
        push_obj(COLOR_GREEN);
        goto(20);
        push_obj(COLOR_RED);
        goto(300);
        chk_fire("indep_fire0", f0_log, 122);
        chk_fire("indep_fire1", f1_log, 202);

        // Overflow: five reds back to back, four survive and fire in order.
        do_reset();
        for (int i = 0; i < 5; i++) push_obj(COLOR_RED);
        chk("ovf_flag", overflow, 2'b01);
        chk("ovf_pending", pending, 4);
        goto(150);
        chk("ovf_fire_count", f0_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (f0_log.size() > k) chk("ovf_fire_time", f0_log[k], 102 + 11 * k);
        end
        chk("ovf_no_fire1", f1_log.size(), 0);
        pulse_clr();
        chk("ovf_cleared", overflow, 2'b00);
        goto(160);
        for (int i = 0; i < 4; i++) push_obj(COLOR_RED);
        clr_flags = 1'b1;
        push_obj(COLOR_RED);
        clr_flags = 1'b0;
        chk("ovf_beats_clear", overflow, 2'b01);

        // Late drop with servo held busy; second drop coincides with a clear.
        do_reset();
        servo_busy = 2'b01;
        push_obj(COLOR_RED);
        goto(10);
        push_obj(COLOR_RED);
        goto(153);
        chk("late_miss", miss_cnt, 16'd1);
        chk("late_miss_wrap", miss_cnt_w, 16'd1);
        goto(161);
        pulse_clr();
        chk("miss_beats_clear", miss_cnt, 16'd1);
        goto(170);
        pulse_clr();
        chk("miss_cleared", miss_cnt, 16'd0);
        goto(200);
        servo_busy = 2'b00;
        goto(300);
        chk("late_no_fire", f0_log.size(), 0);
        chk("late_pending", pending, 0);

        // Reset while three reds are queued.
        do_reset();
        for (int i = 0; i < 3; i++) push_obj(COLOR_RED);
        chk("rst_pending_before", pending, 3);
        goto(50);
        rst_n = 1'b0;
        #1;
        chk("rst_pending_async", pending, 0);
        chk("rst_pending_async_wrap", pending_w, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        goto(300);
        chk("rst_no_fire", f0_log.size() + w0_log.size(), 0);
        chk("rst_pending_after", pending, 0);

        // Randomized traffic, servos idle: each head fires at
        // max(due + 2, previous fire + ACKT + 3) and queues hold DEPTH entries.
        do_reset();
        for (int l = 0; l < 2; l++) begin
            mq[l].delete();
            head_fire[l] = 0;
            last_fire[l] = -1000;
        end
        m_ovf = 2'b00;
        goto(1);
        for (int n = 0; n < 3000; n++) begin
            int t;
            t = cyc;
            obj_valid = ($urandom_range(0, 5) == 0);
            obj_color = 2'($urandom_range(0, 3));
            @(negedge clk);
            for (int l = 0; l < 2; l++)
                exp_fire[l] = (mq[l].size() > 0) && (head_fire[l] == t);
            exp_pend = {3'(mq[1].size()), 3'(mq[0].size())};
            checks++;
            if (fire !== exp_fire || fire_w !== exp_fire || pending !== exp_pend ||
                overflow !== m_ovf || miss_cnt !== 16'd0) begin
                errors++;
                $display("FAIL random cycle=%0d fire=%b wrapfire=%b required=%b pending=%h required=%h overflow=%b required=%b miss=%h required=0",
                         t, fire, fire_w, exp_fire, pending, exp_pend, overflow, m_ovf, miss_cnt);
            end
            for (int l = 0; l < 2; l++) begin
                int size_before;
                size_before = mq[l].size();
                if (exp_fire[l]) begin
                    last_fire[l] = t;
                    void'(mq[l].pop_front());
                end
                if (obj_valid && obj_color == 2'(l + 1)) begin
                    if (mq[l].size() < DEPTH) mq[l].push_back(t + ((l == 0) ? D1 : D2));
                    else m_ovf[l] = 1'b1;
                end
                if (mq[l].size() > 0 && (exp_fire[l] || size_before == 0))
                    head_fire[l] = imax(mq[l][0] + 2, last_fire[l] + ACKT + 3);
            end
            @(posedge clk);
            #1;
        end
        obj_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
